// File: rtl/fp_int_mac.sv
// fp_int_mac: FP16 activation x signed INT weight multiply-accumulate into a
// fixed-point accumulator aligned to a block exponent (exp_min).
// Sequence per operation: IDLE -> MUL (W_WIDTH cycles, serial shift-add)
// -> ALIGN (1 cycle) -> ACC (1 cycle, result and done registered).
// Optional feature macro: FP_INT_MAC_SAT_EN -- when defined, the ACC-stage
// addition saturates to the signed accumulator limits instead of wrapping.
module fp_int_mac #(
  parameter int ACT_WIDTH = 16,
  parameter int W_WIDTH   = 4,
  parameter int ACC_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ACT_WIDTH-1:0] activation,
  input  logic [W_WIDTH-1:0]   weight,
  input  logic [4:0]           exp_min,
  input  logic [ACC_WIDTH-1:0] fixed_point_acc,
  output logic [4:0]           exp_out,
  output logic [ACC_WIDTH-1:0] fixed_point_out,
  output logic                 done
);

  localparam int FRAC_W = 10;
  localparam int MAN_W  = FRAC_W + 1;
  // Product of an unsigned 11-bit mantissa and a signed weight, with one
  // spare bit so negating the most negative product cannot overflow.
  localparam int PROD_W = MAN_W + W_WIDTH + 1;
  localparam int CNT_W  = (W_WIDTH > 1) ? $clog2(W_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(W_WIDTH - 1);
  localparam logic [7:0] ACC_W8 = 8'(ACC_WIDTH);

  typedef enum logic [1:0] {IDLE, MUL, ALIGN, ACC} state_t;

  state_t                     state;
  logic [CNT_W-1:0]           cnt;
  logic signed [PROD_W-1:0]   mcand;
  logic signed [PROD_W-1:0]   prod;
  logic [W_WIDTH-1:0]         wbits;
  logic                       sign;
  logic                       inf_nan;
  logic [4:0]                 exp_eff;
  logic [4:0]                 exp_min_cap;
  logic signed [ACC_WIDTH-1:0] acc_in;
  logic signed [ACC_WIDTH-1:0] aligned;

  // Operand field decode (FP16 layout: sign, 5-bit exponent, 10-bit fraction)
  logic [4:0]       act_exp;
  logic [FRAC_W-1:0] act_frac;
  logic [MAN_W-1:0] act_man;
  logic [4:0]       act_exp_eff;

  // Datapath combinational values
  logic signed [PROD_W-1:0]    prod_signed;
  logic signed [ACC_WIDTH-1:0] prod_ext;
  logic signed [7:0]           shift_d;
  logic [7:0]                  shamt;
  logic signed [ACC_WIDTH-1:0] aligned_next;
  logic signed [ACC_WIDTH-1:0] sum_wrap;
  logic signed [ACC_WIDTH-1:0] sum_next;
  logic                        overflow;

  // Decode the raw activation; subnormals use an implicit 0 and exponent 1
  always_comb begin
    act_exp     = activation[ACT_WIDTH-2 -: 5];
    act_frac    = activation[FRAC_W-1:0];
    act_man     = {(act_exp != 5'd0), act_frac};
    act_exp_eff = (act_exp == 5'd0) ? 5'd1 : act_exp;
  end

  // Sign-apply, exponent alignment and accumulate for the ALIGN/ACC stages
  always_comb begin
    prod_signed = sign ? -prod : prod;
    prod_ext    = {{(ACC_WIDTH-PROD_W){prod_signed[PROD_W-1]}}, prod_signed};
    shift_d     = $signed({3'b000, exp_eff}) - $signed({3'b000, exp_min_cap});
    shamt       = shift_d[7] ? 8'(-shift_d) : 8'(shift_d);
    aligned_next = '0;
    if (inf_nan) begin
      aligned_next = '0;
    end else if (!shift_d[7]) begin
      if (shamt >= ACC_W8) aligned_next = '0;
      else                 aligned_next = prod_ext << shamt;
    end else begin
      if (shamt >= ACC_W8) aligned_next = {ACC_WIDTH{prod_ext[ACC_WIDTH-1]}};
      else                 aligned_next = prod_ext >>> shamt;
    end

    sum_wrap = acc_in + aligned;
    overflow = (acc_in[ACC_WIDTH-1] == aligned[ACC_WIDTH-1]) &&
               (sum_wrap[ACC_WIDTH-1] != acc_in[ACC_WIDTH-1]);
`ifdef FP_INT_MAC_SAT_EN
    if (overflow)
      sum_next = acc_in[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                     : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    else
      sum_next = sum_wrap;
`else
    sum_next = sum_wrap;
`endif
  end

  // Control FSM, serial multiplier and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      cnt             <= '0;
      mcand           <= '0;
      prod            <= '0;
      wbits           <= '0;
      sign            <= 1'b0;
      inf_nan         <= 1'b0;
      exp_eff         <= '0;
      exp_min_cap     <= '0;
      acc_in          <= '0;
      aligned         <= '0;
      exp_out         <= '0;
      fixed_point_out <= '0;
      done            <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mcand       <= PROD_W'(act_man);
            prod        <= '0;
            wbits       <= weight;
            cnt         <= '0;
            sign        <= activation[ACT_WIDTH-1];
            inf_nan     <= (act_exp == 5'd31);
            exp_eff     <= act_exp_eff;
            exp_min_cap <= exp_min;
            acc_in      <= fixed_point_acc;
            state       <= MUL;
          end
        end
        MUL: begin
          // LSB-first; the weight MSB carries negative weight
          if (wbits[0]) begin
            if (cnt == LAST_BIT) prod <= prod - mcand;
            else                 prod <= prod + mcand;
          end
          mcand <= mcand <<< 1;
          wbits <= wbits >> 1;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST_BIT) state <= ALIGN;
        end
        ALIGN: begin
          aligned <= aligned_next;
          state   <= ACC;
        end
        ACC: begin
          fixed_point_out <= sum_next;
          exp_out         <= exp_min_cap;
          done            <= 1'b1;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_int_mac.sv
// tb_fp_int_mac: directed vector table, hand-written multi-cycle sequences
// and randomized operations checked against an arithmetic reference model.
module tb_fp_int_mac;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] activation = '0;
  logic [3:0]  weight = '0;
  logic [4:0]  exp_min = '0;
  logic [31:0] fixed_point_acc = '0;
  logic [4:0]  exp_out;
  logic [31:0] fixed_point_out;
  logic        done;

  int checks = 0;
  int failures = 0;

  fp_int_mac dut (
    .clk(clk), .rst(rst), .start(start), .activation(activation),
    .weight(weight), .exp_min(exp_min), .fixed_point_acc(fixed_point_acc),
    .exp_out(exp_out), .fixed_point_out(fixed_point_out), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h expected=0x%08h", name, got, exp);
    end else begin
      $display("ok   %s value=0x%08h", name, got);
    end
  endtask

  // Reference: real-number rules with plain integer arithmetic
  function automatic logic [31:0] model(input logic [15:0] a, input logic [3:0] w,
                                        input logic [4:0] em, input logic [31:0] acc);
    int     e, m, wi, d;
    longint p, al, s;
    logic [31:0] al32;
    e = int'(a[14:10]);
    if (e == 31) return acc;
    m  = (e == 0) ? int'(a[9:0]) : 1024 + int'(a[9:0]);
    if (e == 0) e = 1;
    wi = $signed(w);
    p  = longint'(m) * longint'(wi);
    if (a[15]) p = -p;
    d = e - int'(em);
    if (d >= 0) al = (d >= 32) ? 64'sd0 : p * (longint'(1) << d);
    else        al = (-d >= 32) ? ((p < 0) ? -64'sd1 : 64'sd0) : (p >>> (-d));
    al32 = al[31:0];
    s = longint'($signed(acc)) + longint'($signed(al32));
`ifdef FP_INT_MAC_SAT_EN
    if (s > 64'sd2147483647)  s = 64'sd2147483647;
    if (s < -64'sd2147483648) s = -64'sd2147483648;
`endif
    return s[31:0];
  endfunction

  // One full operation: issue start, scramble inputs after capture, wait
  // (bounded) for done, then confirm the pulse is single and outputs hold.
  task automatic run_op(input string name, input logic [15:0] a, input logic [3:0] w,
                        input logic [4:0] em, input logic [31:0] acc, input logic [31:0] exp_res);
    int lat;
    logic [31:0] res;
    @(negedge clk);
    activation = a; weight = w; exp_min = em; fixed_point_acc = acc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    activation = 16'($urandom); weight = 4'($urandom);
    exp_min = 5'($urandom); fixed_point_acc = $urandom;
    lat = -1;
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      @(posedge clk); #1;
      if (done) lat = k;
    end
    res = fixed_point_out;
    $display("txn %s act=%04h w=%0d emin=%0d acc=%08h -> out=%08h exp=%0d lat=%0d",
             name, a, $signed(w), em, acc, res, exp_out, lat);
    chk({name, ".latency"}, 32'(lat), 32'd6);
    chk({name, ".result"}, res, exp_res);
    chk({name, ".exp_out"}, 32'(exp_out), 32'(em));
    @(posedge clk); #1;
    chk({name, ".done_low"}, 32'(done), 32'd0);
    chk({name, ".hold"}, fixed_point_out, res);
  endtask

  typedef struct {
    string       name;
    logic [15:0] act;
    logic [3:0]  w;
    logic [4:0]  em;
    logic [31:0] acc;
    logic [31:0] exp_res;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{"basic",    16'h4569, 4'd3,  5'd16, 32'd2,          32'h0000_2078};
    vecs[1] = '{"second",   16'h4AAA, 4'd5,  5'd16, 32'd2,          32'h0000_854A};
    vecs[2] = '{"neg_act",  16'hC569, 4'd3,  5'd16, 32'd2,          32'hFFFF_DF8C};
    vecs[3] = '{"neg_w",    16'h4569, 4'hF,  5'd17, 32'd0,          32'hFFFF_FA97};
    vecs[4] = '{"rshift",   16'h3C00, 4'd1,  5'd17, 32'd0,          32'h0000_0100};
`ifdef FP_INT_MAC_SAT_EN
    vecs[5] = '{"ovf",      16'h3C00, 4'd1,  5'd15, 32'h7FFF_FFFF,  32'h7FFF_FFFF};
`else
    vecs[5] = '{"ovf",      16'h3C00, 4'd1,  5'd15, 32'h7FFF_FFFF,  32'h8000_03FF};
`endif
    vecs[6] = '{"inf",      16'h7C00, 4'd3,  5'd0,  32'h0001_2345,  32'h0001_2345};
    vecs[7] = '{"subnorm",  16'h0001, 4'd7,  5'd1,  32'd0,          32'h0000_0007};
    vecs[8] = '{"floor",    16'hBC00, 4'd1,  5'd20, 32'd0,          32'hFFFF_FFE0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset.out", fixed_point_out, 32'd0);
    chk("reset.exp", 32'(exp_out), 32'd0);
    chk("reset.done", 32'(done), 32'd0);
    @(negedge clk); rst = 1'b1;

    foreach (vecs[i]) run_op(vecs[i].name, vecs[i].act, vecs[i].w, vecs[i].em, vecs[i].acc, vecs[i].exp_res);

    // Back-to-back: second start presented in the cycle right after done
    begin
      int lat;
      @(negedge clk);
      activation = 16'h4569; weight = 4'd3; exp_min = 5'd16; fixed_point_acc = 32'd2; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      lat = -1;
      for (int k = 1; k <= 20 && lat < 0; k++) begin @(posedge clk); #1; if (done) lat = k; end
      chk("b2b.first", fixed_point_out, 32'h0000_2078);
      activation = 16'h4AAA; weight = 4'd5; exp_min = 5'd16; fixed_point_acc = 32'd2; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      lat = -1;
      for (int k = 1; k <= 20 && lat < 0; k++) begin @(posedge clk); #1; if (done) lat = k; end
      $display("txn b2b second out=%08h lat=%0d", fixed_point_out, lat);
      chk("b2b.lat", 32'(lat), 32'd6);
      chk("b2b.second", fixed_point_out, 32'h0000_854A);
    end

    // Start while busy is ignored: exactly one done with the first result
    begin
      int ndone;
      logic [31:0] first_out;
      @(negedge clk);
      activation = 16'h3C00; weight = 4'd2; exp_min = 5'd15; fixed_point_acc = 32'd5; start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      activation = 16'h4569; weight = 4'd7; exp_min = 5'd10; fixed_point_acc = 32'd99; start = 1'b1;
      @(negedge clk); start = 1'b0;
      ndone = 0; first_out = '0;
      for (int k = 0; k < 16; k++) begin
        @(posedge clk); #1;
        if (done) begin ndone++; first_out = fixed_point_out; end
      end
      $display("txn busy_ignore dones=%0d out=%08h", ndone, first_out);
      chk("busy.dones", 32'(ndone), 32'd1);
      chk("busy.result", first_out, 32'd2053);
    end

    // Asynchronous reset three cycles into an operation
    begin
      int ndone;
      @(negedge clk);
      activation = 16'h4AAA; weight = 4'd5; exp_min = 5'd16; fixed_point_acc = 32'd2; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("abort.out", fixed_point_out, 32'd0);
      chk("abort.exp", 32'(exp_out), 32'd0);
      chk("abort.done", 32'(done), 32'd0);
      @(negedge clk); rst = 1'b1;
      ndone = 0;
      for (int k = 0; k < 12; k++) begin @(posedge clk); #1; if (done) ndone++; end
      $display("txn abort dones_after_release=%0d", ndone);
      chk("abort.no_done", 32'(ndone), 32'd0);
    end
    run_op("after_abort", 16'h4569, 4'd3, 5'd16, 32'd2, 32'h0000_2078);

    // Randomized operations against the reference model
    for (int i = 0; i < 150; i++) begin
      logic [15:0] a;
      logic [3:0]  w;
      logic [4:0]  em;
      logic [31:0] acc;
      a = 16'($urandom); w = 4'($urandom); em = 5'($urandom); acc = $urandom;
      if (i % 4 == 0) acc = acc >> ($urandom_range(0, 31));
      run_op($sformatf("rand%0d", i), a, w, em, acc, model(a, w, em, acc));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
